// File: rtl/cpu_step_ctrl.sv
`default_nettype none
//============================================================================
// Module  : cpu_step_ctrl
// Brief   : Run/step/halt sequencer that turns debounced buttons into a
//           one-cycle CPU clock enable and counts issued enables.
// Revision: 1.0
//============================================================================
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RUN_DIV         = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_run,
   input  logic        btn_step,
   input  logic        syscall_halt,
   output logic        cpu_en,
   output logic [1:0]  state,
   output logic [31:0] step_count
);

   localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(RUN_DIV - 1);

   typedef enum logic [1:0] {
      ST_PAUSE = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_DIV_W-1:0]   r_div;
   logic [31:0]          r_step_count;
   logic                 r_live;
   logic [1:0]           w_btn;
   logic [1:0]           w_press;

   assign w_btn = {btn_step, btn_run};

   // r_live marks that the synchronizers hold real samples, not reset values
   always_ff @(posedge clk) begin
      if (rst) r_live <= 1'b0;
      else     r_live <= 1'b1;
   end

   generate
      for (genvar i = 0; i < 2; i++) begin : g_btn
         logic              r_sync1;
         logic              r_sync2;
         logic              r_acc;
         logic              r_acc_q;
         logic              r_armed;
         logic              r_press;
         logic [c_DB_W-1:0] r_cnt;

         // A press is honoured only once the button has been seen released,
         // so a button held through reset cannot fire.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_acc   <= 1'b0;
               r_acc_q <= 1'b0;
               r_armed <= 1'b0;
               r_press <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_btn[i];
               r_sync2 <= r_sync1;
               r_acc_q <= r_acc;
               r_press <= r_acc & ~r_acc_q & r_armed;
               if (r_live && !r_sync1) r_armed <= 1'b1;
               if (r_sync2 == r_acc) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_DB_MAX) begin
                  r_acc <= r_sync2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_DB_W'(1);
               end
            end
         end

         assign w_press[i] = r_press;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_PAUSE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_PAUSE: begin
            if (syscall_halt)    w_state_nxt = ST_HALT;
            else if (w_press[0]) w_state_nxt = ST_RUN;
            else if (w_press[1]) w_state_nxt = ST_STEP;
         end
         ST_STEP: w_state_nxt = syscall_halt ? ST_HALT : ST_PAUSE;
         ST_RUN: begin
            if (syscall_halt)    w_state_nxt = ST_HALT;
            else if (w_press[0]) w_state_nxt = ST_PAUSE;
         end
         default: w_state_nxt = ST_HALT;
      endcase
   end

   // Divider runs only while staying in RUN; entering or leaving clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
      end else if (r_state == ST_RUN && w_state_nxt == ST_RUN) begin
         r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + c_DIV_W'(1);
      end else begin
         r_div <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         r_step_count <= 32'd0;
      else if (cpu_en) r_step_count <= r_step_count + 32'd1;
   end

   assign cpu_en     = (r_state == ST_STEP) || (r_state == ST_RUN && r_div == c_DIV_MAX);
   assign state      = r_state;
   assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
//============================================================================
// Module  : tb_cpu_step_ctrl
// Brief   : Self-checking bench for cpu_step_ctrl against a history-based model.
// Revision: 1.0
//============================================================================
module tb_cpu_step_ctrl;

   localparam int DB  = 4;
   localparam int DIV = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_run = 1'b0;
   logic        btn_step = 1'b0;
   logic        syscall_halt = 1'b0;
   logic        cpu_en;
   logic [1:0]  state;
   logic [31:0] step_count;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_run      (btn_run),
      .btn_step     (btn_step),
      .syscall_halt (syscall_halt),
      .cpu_en       (cpu_en),
      .state        (state),
      .step_count   (step_count)
   );

   always #5 clk = ~clk;

   // Reference model: buttons judged from their sampled history window;
   // index 0 = run button, 1 = step button.
   logic [1:0]  m_state = 2'b00;
   int          m_phase = 0;
   logic [31:0] m_count = 32'd0;
   logic        m_en = 1'b0;
   logic        m_live = 1'b0;
   logic [DB:0] m_hist [2];
   logic        m_acc [2];
   logic        m_rose [2];
   logic        m_armed [2];
   logic        m_pend [2];
   logic        m_ev [2];
   logic        m_newp;
   logic        m_diff;

   always @(posedge clk) begin
      if (rst) begin
         m_state = 2'b00; m_phase = 0; m_count = 32'd0; m_live = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_hist[i] = '0; m_acc[i] = 1'b0; m_rose[i] = 1'b0;
            m_armed[i] = 1'b0; m_pend[i] = 1'b0;
         end
      end else begin
         if (m_en) m_count = m_count + 32'd1;
         for (int i = 0; i < 2; i++) begin
            m_ev[i] = m_pend[i];
            m_newp  = m_rose[i] && m_armed[i];
            m_diff  = 1'b1;
            for (int k = 1; k <= DB; k++)
               if (m_hist[i][k] == m_acc[i]) m_diff = 1'b0;
            m_rose[i] = m_diff && !m_acc[i];
            if (m_diff) m_acc[i] = !m_acc[i];
            if (m_live && !m_hist[i][0]) m_armed[i] = 1'b1;
            m_pend[i] = m_newp;
            m_hist[i] = {m_hist[i][DB-1:0], (i == 0) ? btn_run : btn_step};
         end
         m_live = 1'b1;
         case (m_state)
            2'b00: begin
               if (syscall_halt)  m_state = 2'b11;
               else if (m_ev[0]) begin m_state = 2'b01; m_phase = 0; end
               else if (m_ev[1]) m_state = 2'b10;
            end
            2'b10: m_state = syscall_halt ? 2'b11 : 2'b00;
            2'b01: begin
               if (syscall_halt)  m_state = 2'b11;
               else if (m_ev[0]) m_state = 2'b00;
               else              m_phase = (m_phase + 1) % DIV;
            end
            default: ;
         endcase
      end
      m_en = (m_state == 2'b10) || (m_state == 2'b01 && m_phase == DIV - 1);
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e < 20; e++) begin
         @(negedge clk);
         n_checks++;
         if (state !== 2'b00 || cpu_en !== 1'b0 || step_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d state=%0d en=%0b cnt=%0d, required 0/0/0",
                     e, state, cpu_en, step_count);
         end
      end
   endtask

   task automatic test_step();
      int pulses = 0;
      btn_step = 1'b1;
      for (int e = 0; e < 20; e++) begin
         @(negedge clk);
         n_checks++;
         if ({state, cpu_en, step_count} !== {m_state, m_en, m_count}) begin
            n_fail++;
            $display("FAIL step_model e=%0d got %0d/%0b/%0d required %0d/%0b/%0d",
                     e, state, cpu_en, step_count, m_state, m_en, m_count);
         end
         n_checks++;
         if (cpu_en !== (e == 7)) begin
            n_fail++;
            $display("FAIL step_en_timing e=%0d en=%0b required %0b", e, cpu_en, (e == 7));
         end
         if (e == 9) btn_step = 1'b0;
      end
      n_checks++;
      if (step_count !== 32'd1 || state !== 2'b00) begin
         n_fail++;
         $display("FAIL step_result cnt=%0d state=%0d required 1/0", step_count, state);
      end
      btn_step = 1'b1;
      for (int e = 0; e < 14; e++) begin
         @(negedge clk);
         pulses += cpu_en;
         if (e == 2) btn_step = 1'b0;
      end
      n_checks++;
      if (pulses != 0 || step_count !== 32'd1) begin
         n_fail++;
         $display("FAIL step_glitch pulses=%0d cnt=%0d required 0/1", pulses, step_count);
      end
   endtask

   task automatic test_run();
      int pulses = 0;
      btn_run = 1'b1;
      for (int e = 0; e < 19; e++) begin
         @(negedge clk);
         n_checks++;
         if ({state, cpu_en, step_count} !== {m_state, m_en, m_count}) begin
            n_fail++;
            $display("FAIL run_model e=%0d got %0d/%0b/%0d required %0d/%0b/%0d",
                     e, state, cpu_en, step_count, m_state, m_en, m_count);
         end
         if (e >= 7) begin
            pulses += cpu_en;
            n_checks++;
            if (state !== 2'b01) begin
               n_fail++;
               $display("FAIL run_state e=%0d state=%0d required 1", e, state);
            end
         end
         if (e == 7) btn_run = 1'b0;
      end
      n_checks++;
      if (pulses != 4) begin
         n_fail++;
         $display("FAIL run_pulses got %0d required 4", pulses);
      end
      pulses = 0;
      btn_run = 1'b1;
      for (int e = 0; e < 19; e++) begin
         @(negedge clk);
         n_checks++;
         if ({state, cpu_en, step_count} !== {m_state, m_en, m_count}) begin
            n_fail++;
            $display("FAIL run_stop_model e=%0d got %0d/%0b/%0d required %0d/%0b/%0d",
                     e, state, cpu_en, step_count, m_state, m_en, m_count);
         end
         if (e >= 7) pulses += cpu_en;
         if (e == 7) btn_run = 1'b0;
      end
      n_checks++;
      if (pulses != 0 || state !== 2'b00) begin
         n_fail++;
         $display("FAIL run_stop pulses=%0d state=%0d required 0/0", pulses, state);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] c0 = m_count;
      btn_run = 1'b1;
      btn_step = 1'b1;
      for (int e = 0; e < 12; e++) begin
         @(negedge clk);
         n_checks++;
         if (state === 2'b10) begin
            n_fail++;
            $display("FAIL simul_no_step e=%0d state=%0d required not 2", e, state);
         end
         if (e == 7) begin
            n_checks++;
            if (state !== 2'b01 || step_count !== c0) begin
               n_fail++;
               $display("FAIL simul_run state=%0d cnt=%0d required 1/%0d", state, step_count, c0);
            end
            btn_run = 1'b0;
            btn_step = 1'b0;
         end
      end
   endtask

   task automatic test_halt();
      logic [31:0] exp_cnt;
      for (int w = 0; w < 2 * DIV && !m_en; w++) @(negedge clk);
      n_checks++;
      if (!m_en) begin
         n_fail++;
         $display("FAIL halt_wait_pulse timeout, required a RUN pulse within %0d cycles", 2 * DIV);
      end
      exp_cnt = m_count + 32'd1;
      syscall_halt = 1'b1;
      @(negedge clk);
      n_checks++;
      if (state !== 2'b11 || step_count !== exp_cnt || cpu_en !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_entry state=%0d cnt=%0d en=%0b required 3/%0d/0",
                  state, step_count, cpu_en, exp_cnt);
      end
      syscall_halt = 1'b0;
      btn_run = 1'b1;
      for (int e = 0; e < 30; e++) begin
         @(negedge clk);
         n_checks++;
         if (state !== 2'b11 || cpu_en !== 1'b0 || step_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL halt_sticky e=%0d state=%0d en=%0b cnt=%0d required 3/0/%0d",
                     e, state, cpu_en, step_count, exp_cnt);
         end
         if (e == 7) begin btn_run = 1'b0; btn_step = 1'b1; end
         if (e == 15) btn_step = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (state !== 2'b00 || step_count !== 32'd0) begin
         n_fail++;
         $display("FAIL halt_reset state=%0d cnt=%0d required 0/0", state, step_count);
      end
   endtask

   task automatic test_held_reset();
      btn_run = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e < 35; e++) begin
         @(negedge clk);
         n_checks++;
         if ({state, cpu_en, step_count} !== {m_state, m_en, m_count}) begin
            n_fail++;
            $display("FAIL held_model e=%0d got %0d/%0b/%0d required %0d/%0b/%0d",
                     e, state, cpu_en, step_count, m_state, m_en, m_count);
         end
         if (e < 15) begin
            n_checks++;
            if (state !== 2'b00) begin
               n_fail++;
               $display("FAIL held_no_event e=%0d state=%0d required 0", e, state);
            end
         end
         if (e == 14) btn_run = 1'b0;
         if (e == 24) btn_run = 1'b1;
      end
      n_checks++;
      if (state !== 2'b01) begin
         n_fail++;
         $display("FAIL held_repress state=%0d required 1", state);
      end
      btn_run = 1'b0;
      repeat (8) @(negedge clk);
      btn_run = 1'b1;
      repeat (8) @(negedge clk);
      btn_run = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_wrap();
      force dut.r_step_count = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_step_count;
      btn_step = 1'b1;
      for (int e = 0; e < 16; e++) begin
         @(negedge clk);
         n_checks++;
         if ({state, cpu_en, step_count} !== {m_state, m_en, m_count}) begin
            n_fail++;
            $display("FAIL wrap_model e=%0d got %0d/%0b/%0h required %0d/%0b/%0h",
                     e, state, cpu_en, step_count, m_state, m_en, m_count);
         end
         if (e == 9) btn_step = 1'b0;
      end
      n_checks++;
      if (step_count !== 32'd0) begin
         n_fail++;
         $display("FAIL wrap_count cnt=%0h required 0", step_count);
      end
   endtask

   task automatic test_random();
      int len;
      for (int seg = 0; seg < 150; seg++) begin
         btn_run      = 1'($urandom_range(0, 1));
         btn_step     = 1'($urandom_range(0, 1));
         syscall_halt = ($urandom_range(0, 63) == 0);
         rst          = ($urandom_range(0, 39) == 0);
         len          = $urandom_range(1, 10);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rst = 1'b0;
            n_checks++;
            if ({state, cpu_en, step_count} !== {m_state, m_en, m_count}) begin
               n_fail++;
               $display("FAIL random_model seg=%0d got %0d/%0b/%0d required %0d/%0b/%0d",
                        seg, state, cpu_en, step_count, m_state, m_en, m_count);
            end
         end
      end
      syscall_halt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_step();
      test_run();
      test_simultaneous();
      test_halt();
      test_held_reset();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
